// File: rtl/traffic_intersection_ctrl_pkg.sv
// Shared lamp codes and controller state encoding for the intersection controller.
package traffic_pkg;

    localparam int unsigned LIGHT_W = 2;

    localparam logic [LIGHT_W-1:0] LIGHT_OFF    = 2'b00;
    localparam logic [LIGHT_W-1:0] LIGHT_RED    = 2'b01;
    localparam logic [LIGHT_W-1:0] LIGHT_YELLOW = 2'b10;
    localparam logic [LIGHT_W-1:0] LIGHT_GREEN  = 2'b11;

    localparam int unsigned MAX_PHASES = 8;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        ALLRED = 2'd1,
        GREEN  = 2'd2,
        YELLOW = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/traffic_intersection_ctrl_if.sv
// Sensor-side requests and lamp-driver outputs of the intersection controller.
interface traffic_intersection_ctrl_if #(
    parameter int unsigned NUM_PHASES = 4
);
    localparam int unsigned PW = $clog2(NUM_PHASES);

    logic                    tick;
    logic                    start;
    logic [NUM_PHASES-1:0]   car_req;
    logic [NUM_PHASES-1:0]   ped_req;
    logic [2*NUM_PHASES-1:0] light;
    logic [NUM_PHASES-1:0]   walk;
    logic [NUM_PHASES-1:0]   ped_flash;
    logic [PW-1:0]           active_phase;
    logic                    busy;

    // Sensor front end / time base side.
    modport master (
        output tick, start, car_req, ped_req,
        input  light, walk, ped_flash, active_phase, busy
    );

    // Controller side.
    modport slave (
        input  tick, start, car_req, ped_req,
        output light, walk, ped_flash, active_phase, busy
    );

endinterface

// File: rtl/traffic_intersection_ctrl_rr_phase_select.sv
// Round-robin picker: first pending phase after active_phase (with wrap back to
// active_phase itself), plus a flag for demand on any other phase.
module rr_phase_select #(
    parameter int unsigned NUM_PHASES = 4,
    parameter int unsigned PW         = $clog2(NUM_PHASES)
) (
    input  logic [NUM_PHASES-1:0] pend,
    input  logic [PW-1:0]         active_phase,
    output logic [PW-1:0]         next_phase,
    output logic                  competing
);

    logic        found;
    int unsigned idx;

    // Search upward from active_phase+1; nothing pending keeps active_phase.
    always_comb begin
        next_phase = active_phase;
        competing  = 1'b0;
        found      = 1'b0;
        idx        = 0;
        for (int unsigned i = 1; i <= NUM_PHASES; i++) begin
            idx = (32'(active_phase) + i) % NUM_PHASES;
            if (!found && pend[PW'(idx)]) begin
                next_phase = PW'(idx);
                found      = 1'b1;
            end
        end
        for (int unsigned p = 0; p < NUM_PHASES; p++) begin
            if (pend[PW'(p)] && (PW'(p) != active_phase)) begin
                competing = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Multi-phase intersection controller: round-robin phase service with min/max
// green, car-actuated extension, yellow/all-red clearance and pedestrian intervals.
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned NUM_PHASES = 4,
    parameter int unsigned GREEN_MIN  = 10,
    parameter int unsigned GREEN_MAX  = 30,
    parameter int unsigned YELLOW_DUR = 3,
    parameter int unsigned ALLRED_DUR = 2,
    parameter int unsigned WALK_DUR   = 4,
    parameter int unsigned FLASH_DUR  = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    traffic_intersection_ctrl_if.slave  bus
);

    localparam int unsigned PW   = $clog2(NUM_PHASES);
    localparam int unsigned TMAX = (YELLOW_DUR > ALLRED_DUR) ? YELLOW_DUR : ALLRED_DUR;
    localparam int unsigned CW   = $clog2(TMAX + 1);
    localparam int unsigned GW   = $clog2(GREEN_MAX + 1);
    localparam int unsigned LW   = 2 * NUM_PHASES;

    // Parameter sanity checks at elaboration.
    if (NUM_PHASES < 2 || NUM_PHASES > MAX_PHASES) begin : g_chk_phases
        $error("NUM_PHASES must be within 2..8");
    end
    if (GREEN_MIN < WALK_DUR + FLASH_DUR) begin : g_chk_min
        $error("GREEN_MIN must cover WALK_DUR+FLASH_DUR");
    end
    if (GREEN_MAX < GREEN_MIN) begin : g_chk_max
        $error("GREEN_MAX must be >= GREEN_MIN");
    end
    if (YELLOW_DUR < 1 || ALLRED_DUR < 1) begin : g_chk_clear
        $error("YELLOW_DUR and ALLRED_DUR must be >= 1");
    end

    ctrl_state_t            state_q, state_d;
    logic [PW-1:0]          phase_q, phase_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [GW-1:0]          g_q, g_d, g_inc;
    logic [NUM_PHASES-1:0]  car_pend_q, car_pend_d;
    logic [NUM_PHASES-1:0]  ped_pend_q, ped_pend_d;
    logic [NUM_PHASES-1:0]  clr;
    logic                   ped_served_q, ped_served_d;
    logic                   served_any_q, served_any_d;

    logic [LW-1:0]          light_q, light_d;
    logic [NUM_PHASES-1:0]  walk_q, walk_d;
    logic [NUM_PHASES-1:0]  flash_q, flash_d;
    logic                   busy_q, busy_d;

    logic [PW-1:0]          sel_phase;
    logic                   rr_competing;
    logic                   competing;
    logic                   is_act;

    rr_phase_select #(
        .NUM_PHASES (NUM_PHASES),
        .PW         (PW)
    ) u_rr (
        .pend         (car_pend_q | ped_pend_q),
        .active_phase (phase_q),
        .next_phase   (sel_phase),
        .competing    (rr_competing)
    );

    // Next-state, counters and request latches; outputs decoded from next values.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        g_d          = g_q;
        ped_served_d = ped_served_q;
        served_any_d = served_any_q;
        clr          = '0;
        competing    = rr_competing || !bus.start;
        g_inc        = (g_q >= GW'(GREEN_MAX)) ? g_q : g_q + GW'(1);
        light_d      = '0;
        walk_d       = '0;
        flash_d      = '0;
        busy_d       = 1'b0;
        is_act       = 1'b0;

        case (state_q)
            OFF: begin
                if (bus.start) begin
                    state_d = ALLRED;
                    cnt_d   = CW'(ALLRED_DUR);
                end
            end
            ALLRED: begin
                if (bus.tick) begin
                    if (cnt_q == CW'(1)) begin
                        if (!bus.start) begin
                            state_d = OFF;
                        end else begin
                            // First service after reset always starts at phase 0.
                            state_d      = GREEN;
                            phase_d      = served_any_q ? sel_phase : '0;
                            g_d          = '0;
                            ped_served_d = ped_pend_q[phase_d];
                            clr          = NUM_PHASES'(1) << phase_d;
                            served_any_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            GREEN: begin
                // Exit is judged on the tick that completes the interval, so a
                // green lasts exactly GREEN_MIN..GREEN_MAX ticks.
                if (bus.tick) begin
                    g_d = g_inc;
                    if ((g_inc >= GW'(GREEN_MIN)) && competing &&
                        (!bus.car_req[phase_q] || (g_inc >= GW'(GREEN_MAX)))) begin
                        state_d = YELLOW;
                        cnt_d   = CW'(YELLOW_DUR);
                    end
                end
            end
            YELLOW: begin
                if (bus.tick) begin
                    if (cnt_q == CW'(1)) begin
                        state_d = ALLRED;
                        cnt_d   = CW'(ALLRED_DUR);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: state_d = OFF;
        endcase

        // Clearing for the phase entering green wins over a same-edge set.
        car_pend_d = (car_pend_q | bus.car_req) & ~clr;
        ped_pend_d = (ped_pend_q | bus.ped_req) & ~clr;

        busy_d = (state_d != OFF);
        for (int p = 0; p < NUM_PHASES; p++) begin
            is_act = (PW'(p) == phase_d);
            if (state_d == OFF) begin
                light_d[2*p +: 2] = LIGHT_OFF;
            end else if (is_act && state_d == GREEN) begin
                light_d[2*p +: 2] = LIGHT_GREEN;
            end else if (is_act && state_d == YELLOW) begin
                light_d[2*p +: 2] = LIGHT_YELLOW;
            end else begin
                light_d[2*p +: 2] = LIGHT_RED;
            end
            walk_d[p]  = is_act && (state_d == GREEN) && ped_served_d &&
                         (g_d < GW'(WALK_DUR));
            flash_d[p] = is_act && (state_d == GREEN) && ped_served_d &&
                         (g_d >= GW'(WALK_DUR)) && (g_d < GW'(WALK_DUR + FLASH_DUR));
        end
    end

    // State, counters, latches and registered lamp outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= OFF;
            phase_q      <= '0;
            cnt_q        <= '0;
            g_q          <= '0;
            car_pend_q   <= '0;
            ped_pend_q   <= '0;
            ped_served_q <= 1'b0;
            served_any_q <= 1'b0;
            light_q      <= '0;
            walk_q       <= '0;
            flash_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            g_q          <= g_d;
            car_pend_q   <= car_pend_d;
            ped_pend_q   <= ped_pend_d;
            ped_served_q <= ped_served_d;
            served_any_q <= served_any_d;
            light_q      <= light_d;
            walk_q       <= walk_d;
            flash_q      <= flash_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.light        = light_q;
    assign bus.walk         = walk_q;
    assign bus.ped_flash    = flash_q;
    assign bus.active_phase = phase_q;
    assign bus.busy         = busy_q;

endmodule

// File: doc/traffic_intersection_ctrl.md
# traffic_intersection_ctrl

Parametrised multi-phase intersection controller. It is the N-approach successor to the single-approach smart light. It serves up to 8 signal phases in round-robin order with minimum and maximum green times, car-actuated extension, yellow and all-red clearance, and a per-phase pedestrian walk/flash interval. It contains its own tick-driven interval counter, so no external timer block is needed. It sits between the sensor front end (car/pedestrian detectors, time-base divider) and the lamp drivers.

## Interface
- NUM_PHASES, 4: number of phases, 2..8.
- GREEN_MIN, 10: minimum green, ticks; must be ≥ WALK_DUR+FLASH_DUR (elaboration check).
- GREEN_MAX, 30: maximum green under competing demand, ticks; must be ≥ GREEN_MIN.
- YELLOW_DUR, 3: yellow interval, ticks, ≥1.
- ALLRED_DUR, 2: all-red clearance, ticks, ≥1.
- WALK_DUR, 4: pedestrian walk interval, ticks.
- FLASH_DUR, 3: pedestrian flashing-don't-walk interval, ticks.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; no other reset.
- tick  in  1  one-cycle time-base pulse; all durations are counted in ticks.
- start  in  1  level; 1 = run, 0 = graceful stop to OFF.
- car_req  in  NUM_PHASES  car detector per phase, level or pulse.
- ped_req  in  NUM_PHASES  pedestrian button per phase, pulse.
- light  out  2*NUM_PHASES  per-phase lamp code at bits [2p+1:2p]: 00 off, 01 red, 10 yellow, 11 green.
- walk  out  NUM_PHASES  walk lamp per phase.
- ped_flash  out  NUM_PHASES  flashing don't-walk per phase.
- active_phase  out  $clog2(NUM_PHASES)  phase currently served, or last served.
- busy  out  1  high in every state except OFF.

## Operation
- States: OFF, ALLRED, GREEN, YELLOW.
- Request latches car_pend and ped_pend, one bit per phase:
  - set on the edge where the input is high;
  - car_pend[p] clears on entry to GREEN of p;
  - ped_pend[p] clears on entry to GREEN of p, where it also sets ped_served.
  - A ped_req for the active phase during its own green stays latched for its next service.
- Competing demand: any car_pend or ped_pend bit for a phase other than active_phase, or start=0.
- Round-robin selection: the first phase with a pending request, searching from active_phase+1 upward with wrap. With no request anywhere, select active_phase.
- Transitions:
  - OFF: start=1 → ALLRED. next_phase is 0 on the first entry after reset; otherwise it is the round-robin selection.
  - ALLRED: runs ALLRED_DUR ticks. On expiry, start=0 → OFF; otherwise → GREEN of the selected phase.
  - GREEN: counter g counts ticks from 0 and saturates at GREEN_MAX. Leave for YELLOW when g ≥ GREEN_MIN and competing demand exists and either car_req[active]=0 or g ≥ GREEN_MAX. With no competing demand the phase rests in green indefinitely.
  - YELLOW: runs YELLOW_DUR ticks, then → ALLRED.
- Outputs (Moore decode of registered state):
  - active phase is 11 in GREEN and 10 in YELLOW; all other phases are 01; every phase is 01 in ALLRED and 00 in OFF.
  - walk[active] = ped_served && g < WALK_DUR.
  - ped_flash[active] = ped_served && WALK_DUR ≤ g < WALK_DUR+FLASH_DUR.
  - All other walk and ped_flash bits are 0.
- Reset, including mid-operation: state OFF, all latches and counters 0, active_phase 0, light all 00, walk 0, ped_flash 0, busy 0, effective from the cycle after the reset edge.

## Timing
- A timed state of duration D lasts exactly D ticks:
  - the counter loads D on entry and decrements on each tick;
  - the transition happens on the edge where the count is 1 and tick=1.
- A request high in cycle n is latched at edge n and first affects decisions in cycle n+1.
- start is sampled every cycle, with no extra latency.
- Simultaneous set and clear of a latch for the phase entering GREEN: clear wins.
- tick held high continuously means one tick per cycle, which is legal.
- Outputs change on the clock edge that changes state or g; there are no combinational paths from inputs to outputs.

## Structure
- Package traffic_pkg holds:
  - light code constants LIGHT_OFF/RED/YELLOW/GREEN;
  - the ctrl_state_t enum (OFF, ALLRED, GREEN, YELLOW).
- One sub-module, rr_phase_select: a combinational round-robin picker. Inputs are the pending vector and active_phase; outputs are next_phase and a competing flag.
- The top level holds the FSM, the interval counter, the g counter and the request latches.

## Test plan
All scenarios use the defaults with tick=1 every cycle.
- Reset, then start=1 with no requests → 2 cycles ALLRED (light=8'h55), then phase 0 green (light=8'h57) held for 100+ cycles; busy=1.
- During phase-0 green at g=3, pulse car_req[2] with car_req[0]=0 → yellow at g=10, then 3 yellow + 2 all-red, then phase 2 green (light=8'h75); phase 1 is skipped.
- car_req[0] held high and car_req[1] pulsed → phase 0 green lasts exactly 30 ticks, then yellow.
- Pulse ped_req[3] while phase 1 is green → on phase 3 green: walk[3]=1 for 4 cycles, ped_flash[3]=1 for 3 cycles, then 0; ped_pend[3] cleared.
- During phase 2 green, pulse car_req[1] and car_req[3] in the same cycle → phase 3 is served before phase 1.
- Drop start at g=5 with no other demand → yellow at g=10, then all-red, then OFF (light=0, busy=0).
- Assert reset mid-yellow → OFF on the next cycle with all latches clear.
